// File: rtl/sync_fifo_spram_fwft.sv
// Single-port RAM bank: one read or one write per cycle, read data registered.
// Latency: read data valid the cycle after an en & ~wen access; writes land at the edge.
// Backpressure: none; the caller guarantees at most one access per cycle.
module sp_ram_model #(
    parameter int WIDTH = 8,
    parameter int WORDS = 8,
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic             clk,
    input  logic             en,
    input  logic             wen,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (wen) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// FWFT synchronous FIFO over two interleaved single-port RAM banks.
// Latency: write to empty visible next cycle; pop shows the next entry next cycle.
// Backpressure: registered full drops writes (ovf pulse); pop on empty pulses udf.
module sync_fifo_spram_fwft #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr,
    input  logic [WIDTH-1:0] din,
    input  logic             rd,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic [CW-1:0]    used_cnt,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             ovf,
    output logic             udf
);

    localparam int IW = $clog2(DEPTH);
    localparam int AW = IW - 1;
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
        return (i == LAST) ? '0 : i + IW'(1);
    endfunction

    // Output stage: o0 is the head, o1 the skid slot; oc counts valid slots.
    logic [1:0]       oc;
    logic [WIDTH-1:0] o0, o1;
    logic             infl, infl_bank;

    // RAM side: entries [rp, wp) mod DEPTH, including the one parked in staging.
    logic [IW-1:0]    rp, wp, stg_idx;
    logic             stg_vld;
    logic [WIDTH-1:0] stg_dat;
    logic [CW-1:0]    ram_cnt;

    logic             wr_acc, pop, room, rd_ok, rd_issue, bypass;
    logic             wr_ram, to_stg, direct, drain;
    logic [1:0]       keep;
    logic [1:0]       acc_rd, acc_dir, acc_drn;
    logic [1:0]       ram_en, ram_wen;
    logic [AW-1:0]    ram_addr [2];
    logic [WIDTH-1:0] ram_wdat [2];
    logic [WIDTH-1:0] ram_rdat [2];
    logic [WIDTH-1:0] ld_dat, o0_n, o1_n;
    logic [1:0]       oc_n;
    logic [CW-1:0]    used_n, ram_cnt_n;

    assign dout     = o0;
    assign dout_vld = (oc != 2'd0);

    assign wr_acc   = wr & ~full & ~clr;
    assign pop      = rd & dout_vld & ~clr;
    assign keep     = oc - {1'b0, pop};
    // Prefetch/bypass only while the output stage plus the in-flight read stays within two slots.
    assign room     = ({1'b0, keep} + {2'b0, infl}) <= 3'd1;
    assign rd_ok    = (ram_cnt != '0) & ~(stg_vld & (rp == stg_idx));
    assign rd_issue = ~clr & rd_ok & room;
    assign bypass   = wr_acc & (ram_cnt == '0) & room;
    assign wr_ram   = wr_acc & ~bypass;
    // A write colliding with the prefetch bank parks in staging; staging always drains next cycle,
    // and by then the read has moved to the opposite bank.
    assign to_stg   = wr_ram & rd_issue & (wp[0] == rp[0]);
    assign direct   = wr_ram & ~to_stg;
    assign drain    = stg_vld & ~clr;

    assign acc_rd   = rd_issue ? (2'b01 << rp[0])      : 2'b00;
    assign acc_dir  = direct   ? (2'b01 << wp[0])      : 2'b00;
    assign acc_drn  = drain    ? (2'b01 << stg_idx[0]) : 2'b00;

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            ram_en[b]   = acc_rd[b] | acc_dir[b] | acc_drn[b];
            ram_wen[b]  = ~acc_rd[b];
            ram_addr[b] = acc_rd[b]  ? rp[IW-1:1] :
                          acc_drn[b] ? stg_idx[IW-1:1] : wp[IW-1:1];
            ram_wdat[b] = acc_drn[b] ? stg_dat : din;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        sp_ram_model #(.WIDTH(WIDTH), .WORDS(DEPTH / 2)) u_ram (
            .clk   (clk),
            .en    (ram_en[b]),
            .wen   (ram_wen[b]),
            .addr  (ram_addr[b]),
            .wdata (ram_wdat[b]),
            .rdata (ram_rdat[b])
        );
    end

    assign ld_dat = infl_bank ? ram_rdat[1] : ram_rdat[0];

    // Refill order behind the surviving entries: landing RAM read first, then bypassed write.
    always_comb begin
        o0_n = o0;
        o1_n = o1;
        oc_n = keep;
        if (pop && oc == 2'd2) begin
            o0_n = o1;
        end
        if (infl) begin
            if (oc_n == 2'd0) o0_n = ld_dat;
            else              o1_n = ld_dat;
            oc_n = oc_n + 2'd1;
        end
        if (bypass) begin
            if (oc_n == 2'd0) o0_n = din;
            else              o1_n = din;
            oc_n = oc_n + 2'd1;
        end
    end

    always_comb begin
        used_n = used_cnt;
        if (wr_acc && !pop)      used_n = used_cnt + CW'(1);
        else if (pop && !wr_acc) used_n = used_cnt - CW'(1);
        ram_cnt_n = ram_cnt;
        if (wr_ram && !rd_issue)      ram_cnt_n = ram_cnt + CW'(1);
        else if (rd_issue && !wr_ram) ram_cnt_n = ram_cnt - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oc <= '0; o0 <= '0; o1 <= '0; infl <= 1'b0; infl_bank <= 1'b0;
            rp <= '0; wp <= '0; stg_idx <= '0; stg_vld <= 1'b0; stg_dat <= '0;
            ram_cnt <= '0; used_cnt <= '0;
            full <= 1'b0; empty <= 1'b1; almost_full <= 1'b0; almost_empty <= 1'b1;
            ovf <= 1'b0; udf <= 1'b0;
        end else if (clr) begin
            oc <= '0; o0 <= '0; o1 <= '0; infl <= 1'b0; infl_bank <= 1'b0;
            rp <= '0; wp <= '0; stg_idx <= '0; stg_vld <= 1'b0; stg_dat <= '0;
            ram_cnt <= '0; used_cnt <= '0;
            full <= 1'b0; empty <= 1'b1; almost_full <= 1'b0; almost_empty <= 1'b1;
            ovf <= 1'b0; udf <= 1'b0;
        end else begin
            oc        <= oc_n;
            o0        <= o0_n;
            o1        <= o1_n;
            infl      <= rd_issue;
            infl_bank <= rp[0];
            if (rd_issue) rp <= nxt(rp);
            if (wr_ram)   wp <= nxt(wp);
            if (to_stg) begin
                stg_vld <= 1'b1;
                stg_idx <= wp;
                stg_dat <= din;
            end else if (drain) begin
                stg_vld <= 1'b0;
            end
            ram_cnt      <= ram_cnt_n;
            used_cnt     <= used_n;
            full         <= (used_n == CW'(DEPTH));
            empty        <= (used_n == '0);
            almost_full  <= (used_n >= CW'(AFULL_TH));
            almost_empty <= (used_n <= CW'(AEMPTY_TH));
            ovf          <= wr & full;
            udf          <= rd & ~dout_vld;
        end
    end

endmodule

// File: tb/tb_sync_fifo_spram_fwft.sv
// Directed and scoreboarded checks for the interleaved single-port FWFT FIFO.
module tb_sync_fifo_spram_fwft;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n, clr, wr, rd;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             dout_vld, full, empty, almost_full, almost_empty, ovf, udf;
    logic [CW-1:0]    used_cnt;

    int n_chk = 0;
    int n_err = 0;

    sync_fifo_spram_fwft #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(DEPTH - 2), .AEMPTY_TH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .wr           (wr),
        .din          (din),
        .rd           (rd),
        .dout         (dout),
        .dout_vld     (dout_vld),
        .used_cnt     (used_cnt),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .ovf          (ovf),
        .udf          (udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dout"},  int'(dout), 0);
        chk({tag, "_vld"},   int'(dout_vld), 0);
        chk({tag, "_used"},  int'(used_cnt), 0);
        chk({tag, "_full"},  int'(full), 0);
        chk({tag, "_empty"}, int'(empty), 1);
        chk({tag, "_afull"}, int'(almost_full), 0);
        chk({tag, "_aempty"}, int'(almost_empty), 1);
        chk({tag, "_ovf"},   int'(ovf), 0);
        chk({tag, "_udf"},   int'(udf), 0);
    endtask

    // Each bank must see at most one access per cycle; sampled just before the active edge.
    always begin
        @(negedge clk);
        #4;
        if (rst_n === 1'b1) begin
            chk("bank_clash",
                int'(|((dut.acc_rd & dut.acc_dir) | (dut.acc_rd & dut.acc_drn) | (dut.acc_dir & dut.acc_drn))),
                0);
        end
    end

    logic [WIDTH-1:0] q[$];
    int wr_pct, rd_pct;
    logic exp_ovf, exp_udf, w_acc, p_acc;

    initial begin
        rst_n = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0; din = '0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single write into empty FIFO is visible the next cycle.
        wr = 1'b1; din = 8'hA5;
        step();
        wr = 1'b0;
        chk("w1_vld", int'(dout_vld), 1);
        chk("w1_dout", int'(dout), 'hA5);
        chk("w1_used", int'(used_cnt), 1);
        chk("w1_empty", int'(empty), 0);
        chk("w1_aempty", int'(almost_empty), 1);
        rd = 1'b1;
        step();
        rd = 1'b0;
        chk("w1_pop_used", int'(used_cnt), 0);
        chk("w1_pop_vld", int'(dout_vld), 0);

        // Fill to full, then one overflowing write.
        for (int i = 0; i < DEPTH; i++) begin
            wr = 1'b1; din = WIDTH'(i);
            step();
            chk("fill_used", int'(used_cnt), i + 1);
            chk("fill_afull", int'(almost_full), (i + 1 >= 14) ? 1 : 0);
            chk("fill_full", int'(full), (i == DEPTH - 1) ? 1 : 0);
        end
        din = 8'hFF;
        step();
        wr = 1'b0;
        chk("ovf_pulse", int'(ovf), 1);
        chk("ovf_used", int'(used_cnt), 16);
        step();
        chk("ovf_single", int'(ovf), 0);

        // Drain back-to-back: strict order, no bubbles.
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_vld", int'(dout_vld), 1);
            chk("drain_dat", int'(dout), i);
            chk("drain_afull", int'(almost_full), (16 - i >= 14) ? 1 : 0);
            chk("drain_aempty", int'(almost_empty), (16 - i <= 2) ? 1 : 0);
            rd = 1'b1;
            step();
        end
        rd = 1'b0;
        chk("drain_empty", int'(empty), 1);
        chk("drain_used", int'(used_cnt), 0);
        chk("drain_vld_end", int'(dout_vld), 0);

        // Sustained write+pop at occupancy 3, wrapping the pointers many times.
        for (int i = 0; i < 3; i++) begin
            wr = 1'b1; din = WIDTH'(i);
            step();
        end
        for (int k = 0; k < 100; k++) begin
            chk("stream_used", int'(used_cnt), 3);
            chk("stream_vld", int'(dout_vld), 1);
            chk("stream_dat", int'(dout), k);
            wr = 1'b1; rd = 1'b1; din = WIDTH'(k + 3);
            step();
        end
        wr = 1'b0; rd = 1'b0;
        chk("stream_end_used", int'(used_cnt), 3);
        chk("stream_end_dat", int'(dout), 100);

        // Reach 9 entries, then clear together with wr and rd.
        for (int i = 0; i < 6; i++) begin
            wr = 1'b1; din = WIDTH'(103 + i);
            step();
        end
        wr = 1'b0;
        chk("pre_clr_used", int'(used_cnt), 9);
        clr = 1'b1; wr = 1'b1; rd = 1'b1; din = 8'h77;
        step();
        clr = 1'b0; wr = 1'b0; rd = 1'b0;
        chk_reset_vals("clr");

        // Pop on empty: single udf pulse, nothing else moves.
        rd = 1'b1;
        step();
        rd = 1'b0;
        chk("udf_pulse", int'(udf), 1);
        chk("udf_used", int'(used_cnt), 0);
        chk("udf_dout", int'(dout), 0);
        chk("udf_vld", int'(dout_vld), 0);
        step();
        chk("udf_single", int'(udf), 0);

        wr = 1'b1; din = 8'h3C;
        step();
        wr = 1'b0;
        chk("post_clr_vld", int'(dout_vld), 1);
        chk("post_clr_dout", int'(dout), 'h3C);
        chk("post_clr_used", int'(used_cnt), 1);
        rd = 1'b1;
        step();
        rd = 1'b0;
        chk("post_clr_pop", int'(used_cnt), 0);

        // Random traffic against a queue model, with an async reset mid-stream.
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            if (c < 3000)      begin wr_pct = 70; rd_pct = 40; end
            else if (c < 6000) begin wr_pct = 40; rd_pct = 70; end
            else               begin wr_pct = 55; rd_pct = 55; end
            chk("rnd_used", int'(used_cnt), q.size());
            chk("rnd_full", int'(full), (q.size() == DEPTH) ? 1 : 0);
            chk("rnd_empty", int'(empty), (q.size() == 0) ? 1 : 0);
            if (dout_vld) begin
                if (q.size() == 0) chk("rnd_vld_on_empty", 1, 0);
                else               chk("rnd_dat", int'(dout), int'(q[0]));
            end
            wr  = ($urandom_range(99) < wr_pct);
            rd  = ($urandom_range(99) < rd_pct);
            din = WIDTH'($urandom);
            w_acc   = wr && (q.size() < DEPTH);
            exp_ovf = wr && (q.size() == DEPTH);
            p_acc   = rd && dout_vld;
            exp_udf = rd && !dout_vld;
            step();
            if (p_acc && q.size() > 0) void'(q.pop_front());
            if (w_acc) q.push_back(din);
            chk("rnd_ovf", int'(ovf), int'(exp_ovf));
            chk("rnd_udf", int'(udf), int'(exp_udf));
            if (c == 5000) begin
                #2;
                rst_n = 1'b0; wr = 1'b0; rd = 1'b0;
                #1;
                chk_reset_vals("async_rst");
                q.delete();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        wr = 1'b0; rd = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_spram_fwft.md
# sync_fifo_spram_fwft

Parametrised synchronous FIFO storing data in two single-port RAM banks (even/odd entry interleave, `sp_ram_model`, DEPTH/2 words each) with first-word-fall-through output, programmable almost-full/almost-empty thresholds, synchronous flush and overflow/underflow pulses. It is the drop-in successor for buffering between pipeline stages where dual-port RAM is unavailable. It must sustain one write plus one pop per cycle indefinitely.

## Interface
- `WIDTH`, 8, data width in bits (>=1).
- `DEPTH`, 16, entries; even, >=4.
- `AFULL_TH`, DEPTH-2, `almost_full` asserted when `used_cnt >= AFULL_TH`.
- `AEMPTY_TH`, 2, `almost_empty` asserted when `used_cnt <= AEMPTY_TH`.
- `CW` (localparam), `$clog2(DEPTH+1)`, count width; `DEPTH` must be representable.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous flush.
- `wr`  in  1  write request.
- `din`  in  WIDTH  write data.
- `rd`  in  1  pop; consumes `dout` when `dout_vld`.
- `dout`  out  WIDTH  head entry, valid when `dout_vld`.
- `dout_vld`  out  1  head entry present.
- `used_cnt`  out  CW  entries held (RAM, staging and output registers combined).
- `full`, `empty`, `almost_full`, `almost_empty`  out  1  status.
- `ovf`, `udf`  out  1  single-cycle error pulses.

## Operation
- Accepted write: `wr & ~full` (registered `full`; a same-cycle `rd` does not unblock it). `wr & full` drops the data and pulses `ovf`.
- Accepted pop: `rd & dout_vld`. `rd & ~dout_vld` pulses `udf`; no state change.
- `used_cnt` updates every cycle as +1 (write only), -1 (pop only) or unchanged (both or neither).
- `full = (used_cnt == DEPTH)`.
- `empty = (used_cnt == 0)`.
- `empty` is equivalent to `~dout_vld` once any bypass or prefetch has settled; `dout_vld` may lag `used_cnt` by at most 1 cycle.
- Entry k goes to bank k[0], bank address k>>1. Each bank performs at most one access (read or write) per cycle.
- Bank conflicts (write and prefetch read targeting the same bank) are resolved by a one-entry write staging register that drains on the next cycle. Neither throughput nor order may be lost.
- Output stage: a 2-entry prefetch/skid register.
  - `dout` changes only on an accepted pop or when `dout_vld` rises.
  - `dout` holds its value while `rd=0`.
- Bypass: a write into a completely empty FIFO loads the output register directly.
- Pointers wrap modulo DEPTH. Order is strictly preserved across wrap.
- `clr` takes priority over `wr`/`rd` in the same cycle and discards them. Next cycle: all pointers, staging and output registers are cleared, and status equals reset values. No `ovf`/`udf` pulse is generated in a `clr` cycle.
- RAM contents are not cleared by reset or `clr`.

## Timing
- Reset values:
  - `dout`=0, `dout_vld`=0, `used_cnt`=0
  - `full`=0, `empty`=1, `almost_full`=0, `almost_empty`=1
  - `ovf`=0, `udf`=0
- Write-to-visible latency: a write accepted at edge N into an empty FIFO gives `dout_vld=1`, `dout=din` after edge N (the next cycle).
- Pop-to-next latency: with more entries available, `dout` shows the next entry in the cycle after the pop edge. There are no bubbles under continuous `rd=1`.
- Status flags and `used_cnt` are registered and update one edge after the causing request.
- `ovf`/`udf` are high for exactly the cycle after the offending request edge.
- `sp_ram_model` read data is valid one cycle after an `en & ~wen` access. Prefetch must issue reads early enough to meet the pop-to-next latency.
- Reset mid-operation: all outputs return to their reset values asynchronously. Operation resumes on the first edge after release.

## Test plan
- Reset, then 1 write of 0xA5 -> next cycle `dout_vld=1`, `dout=0xA5`, `used_cnt=1`, `empty=0`, `almost_empty=1`.
- Write 16 entries 0..15 (DEPTH=16) with no reads:
  - `full=1` and `used_cnt=16` after the 16th write.
  - A 17th `wr` pulses `ovf` and `used_cnt` stays 16.
  - Draining returns 0..15 in order; `almost_full` is set from `used_cnt=14`.
- Simultaneous `wr=1`, `rd=1` for 100 cycles with an incrementing pattern, starting at `used_cnt=3`:
  - `used_cnt` stays 3.
  - `dout` increments every cycle with no gaps.
  - Pointers wrap more than 6 times; neither bank is ever accessed twice in one cycle (assertion).
- `rd` on an empty FIFO -> `udf` high for one cycle; `used_cnt` stays 0; `dout` unchanged.
- At `used_cnt=9`, assert `clr` together with `wr`, `rd` -> next cycle `used_cnt=0`, `empty=1`, `dout_vld=0`, no `ovf`/`udf`. A subsequent write of 0x3C appears on `dout` one cycle later.
- Random `wr`/`rd` for 10k cycles against a queue scoreboard, with `rst_n` asserted asynchronously mid-stream -> all outputs equal reset values immediately; the scoreboard flushes and matches thereafter.
